fetch_stage: RTL and testbench

//  Instruction-fetch stage. Owns the program counter, issues one request at a time to the

---
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, and
// presents {PC+4, instruction} or a zero bubble with fetch_stall raised.
module fetch_stage #(
  parameter int                  WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brTaken,
  input  logic [WORD_LEN-1:0] brAddr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [WORD_LEN-1:0] imem_data,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                fetch_stall
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t              state, state_nxt;
  logic [WORD_LEN-1:0] pc_reg, pc_nxt, buf_reg, buf_nxt, pc_inc;
  logic [WORD_LEN-1:0] pres_instr;
  logic                req, pres;

  assign pc_inc = pc_reg + WORD_LEN'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ISSUE;
      pc_reg  <= RESET_PC;
      buf_reg <= '0;
    end else begin
      state   <= state_nxt;
      pc_reg  <= pc_nxt;
      buf_reg <= buf_nxt;
    end
  end

  // Redirect is checked first in every state: it always beats freeze.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc_reg;
    buf_nxt    = buf_reg;
    req        = 1'b0;
    pres       = 1'b0;
    pres_instr = '0;
    case (state)
      ISSUE: begin
        req = 1'b1;
        if (brTaken) begin
          pc_nxt    = brAddr;
          state_nxt = DROP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (brTaken) begin
          pc_nxt    = brAddr;
          state_nxt = imem_valid ? ISSUE : DROP;
        end else if (imem_valid) begin
          pres       = 1'b1;
          pres_instr = imem_data;
          if (freeze) begin
            buf_nxt   = imem_data;
            state_nxt = HOLD;
          end else begin
            pc_nxt    = pc_inc;
            state_nxt = ISSUE;
          end
        end
      end
      HOLD: begin
        pres       = 1'b1;
        pres_instr = buf_reg;
        if (brTaken) begin
          pc_nxt    = brAddr;
          buf_nxt   = '0;
          state_nxt = ISSUE;
        end else if (!freeze) begin
          pc_nxt    = pc_inc;
          state_nxt = ISSUE;
        end
      end
      DROP: begin
        if (brTaken) pc_nxt = brAddr;
        if (imem_valid) state_nxt = ISSUE;
      end
      default: state_nxt = ISSUE;
    endcase
  end

  // State sits at ISSUE during reset; gating keeps the request and outputs quiet.
  assign imem_req    = req & rst;
  assign imem_addr   = pc_reg;
  assign PC          = (pres && rst) ? pc_inc : '0;
  assign instruction = (pres && rst) ? pres_instr : '0;
  assign fetch_stall = ~(pres & rst);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-varying memory, a transaction
// scoreboard of expected presentations, and an expected-fetch-address model.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0, rst = 1'b0, freeze = 1'b0, brTaken = 1'b0, imem_valid = 1'b0;
  logic [31:0] brAddr = '0, imem_data = '0;
  logic        imem_req, fetch_stall;
  logic [31:0] imem_addr, PC, instruction;

  fetch_stage #(.WORD_LEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .brTaken(brTaken), .brAddr(brAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_data(imem_data), .PC(PC), .instruction(instruction), .fetch_stall(fetch_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } pres_t;
  pres_t sb[$];
  int    n_chk = 0, n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver and memory: a response is live only if no redirect happened between
  // its request and its arrival (arrival cycle included).
  initial begin
    bit          outst, quiet, pulsed;
    logic [31:0] oaddr;
    int          oep, ocnt, epoch, rst_left;
    outst = 0; epoch = 0; pulsed = 0; rst_left = 0; oaddr = '0; oep = 0; ocnt = 0;
    repeat (3) @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rst_left > 0) begin
        rst = 1'b0; rst_left--;
      end else begin
        rst = 1'b1;
      end
      if (!pulsed && cyc >= 1500 && outst) begin
        rst = 1'b0; rst_left = 1; pulsed = 1;
      end
      if (!rst) begin
        freeze = 1'b0; brTaken = 1'b0; imem_valid = 1'b0; outst = 0;
        continue;
      end
      quiet   = (cyc < 12);
      freeze  = !quiet && ($urandom_range(0, 99) < 35);
      brTaken = !quiet && ($urandom_range(0, 99) < 8);
      brAddr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_FFFC);
      imem_valid = 1'b0;
      if (outst) begin
        if (ocnt == 0) begin
          imem_valid = 1'b1;
          imem_data  = mem(oaddr);
          if (oep == epoch && !brTaken) sb.push_back({oaddr + 32'd4, mem(oaddr)});
          outst = 0;
        end else begin
          ocnt--;
        end
      end
      #1;
      if (imem_req) begin
        chk("one_outstanding", {31'b0, outst}, 32'd0);
        outst = 1; oaddr = imem_addr; oep = epoch;
        ocnt  = quiet ? 0 : $urandom_range(0, 3);
      end
      if (brTaken) epoch++;
    end
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  // Monitor: anything in the scoreboard must be on the outputs; otherwise a bubble.
  initial begin
    logic [31:0] exp_pc;
    int          idle;
    exp_pc = RPC; idle = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_pc", PC, 32'd0);
        chk("rst_ins", instruction, 32'd0);
        chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        sb.delete(); exp_pc = RPC; idle = 0;
        continue;
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, exp_pc);
        idle = 0;
      end else if (++idle > 64) begin
        chk("progress_idle_cycles", idle, 32'd0);
        idle = 0;
      end
      if (sb.size() != 0) begin
        chk("stall", {31'b0, fetch_stall}, 32'd0);
        chk("pc", PC, sb[0].pc);
        chk("ins", instruction, sb[0].ins);
        if (brTaken || !freeze) begin
          if (!brTaken) exp_pc = sb[0].pc;
          void'(sb.pop_front());
        end
      end else begin
        chk("bubble_stall", {31'b0, fetch_stall}, 32'd1);
        chk("bubble_pc", PC, 32'd0);
        chk("bubble_ins", instruction, 32'd0);
      end
      if (brTaken) exp_pc = brAddr;
    end
  end
endmodule
